// File: rtl/bnn_pkg.sv
// Shared types and default geometry for the binary convolution layer sequencer.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic MODE_CONV3 = 1'b0;
  localparam logic MODE_CONV2 = 1'b1;

  localparam int DEF_W_CONV3 = 12;
  localparam int DEF_W_CONV2 = 14;
  localparam int DEF_H       = 12;
  localparam int DEF_AW      = 8;
  localparam int DEF_OCW     = 6;
  localparam int DEF_PIPE    = 3;

  function automatic logic [3:0] layer_onehot(input logic [1:0] layer);
    return 4'b0001 << layer;
  endfunction

endpackage

// File: rtl/bnn_conv_seq_if.sv
// Control/streaming bundle between the layer controller, the sequencer and the engine side.
interface bnn_conv_seq_if
  import bnn_pkg::*;
#(
  parameter int AW  = DEF_AW,
  parameter int OCW = DEF_OCW
) ();

  logic           iGO;
  logic           iMODE;
  logic [1:0]     iLAYER;
  logic [OCW-1:0] iN_OC;
  logic           oBUSY;
  logic           oDONE;
  logic           oRD_EN;
  logic [AW-1:0]  oRD_ADDR;
  logic [OCW-1:0] oW_ADDR;
  logic [3:0]     oSTART;
  logic           oEN_conv2;
  logic           oEN_conv3;
  logic           oOUT_VALID;
  logic [OCW-1:0] oOUT_OC;
  logic [3:0]     oOUT_ROW;
  logic [3:0]     oOUT_COL;

  modport master (
    output iGO, iMODE, iLAYER, iN_OC,
    input  oBUSY, oDONE, oRD_EN, oRD_ADDR, oW_ADDR, oSTART, oEN_conv2, oEN_conv3,
    input  oOUT_VALID, oOUT_OC, oOUT_ROW, oOUT_COL
  );

  modport slave (
    input  iGO, iMODE, iLAYER, iN_OC,
    output oBUSY, oDONE, oRD_EN, oRD_ADDR, oW_ADDR, oSTART, oEN_conv2, oEN_conv3,
    output oOUT_VALID, oOUT_OC, oOUT_ROW, oOUT_COL
  );

endinterface

// File: rtl/bnn_tag_pipe.sv
// Fixed-depth delay line carrying the window-valid flag and its (oc,row,col) tag
// so results line up with the engine's registered output.
module bnn_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int TW    = 14
) (
  input  logic          i_clk,
  input  logic          i_clr_n,
  input  logic          i_valid,
  input  logic [TW-1:0] i_tag,
  output logic          o_valid,
  output logic [TW-1:0] o_tag
);

  logic [DEPTH:0]         w_vld;
  logic [DEPTH:0][TW-1:0] w_tag;

  assign w_vld[0] = i_valid;
  assign w_tag[0] = i_tag;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic          r_vld;
      logic [TW-1:0] r_tag;

      always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
          r_vld <= 1'b0;
          r_tag <= '0;
        end else begin
          r_vld <= w_vld[gi];
          r_tag <= w_tag[gi];
        end
      end

      assign w_vld[gi+1] = r_vld;
      assign w_tag[gi+1] = r_tag;
    end
  endgenerate

  assign o_valid = w_vld[DEPTH];
  assign o_tag   = w_tag[DEPTH];

endmodule

// File: rtl/bnn_conv_seq.sv
// Layer sequencer: streams the input map once per output channel, drives engine
// enables and tags every completed 3x3 window result.
module bnn_conv_seq
  import bnn_pkg::*;
#(
  parameter int W_CONV3 = DEF_W_CONV3,
  parameter int W_CONV2 = DEF_W_CONV2,
  parameter int H       = DEF_H,
  parameter int AW      = DEF_AW,
  parameter int OCW     = DEF_OCW,
  parameter int PIPE    = DEF_PIPE
) (
  input  logic                iCLK,
  input  logic                iRST,
  bnn_conv_seq_if.slave       bus
);

  localparam int TW = OCW + 8;
  localparam logic [3:0] W3_LAST   = 4'(W_CONV3 - 1);
  localparam logic [3:0] W2_LAST   = 4'(W_CONV2 - 1);
  localparam logic [3:0] ROW_LAST  = 4'(H - 1);
  localparam logic [3:0] DRN_LAST  = 4'(PIPE - 1);

  state_t         r_state;
  logic           r_mode;
  logic [1:0]     r_layer;
  logic [OCW-1:0] r_n_oc;
  logic [OCW-1:0] r_oc;
  logic [3:0]     r_row;
  logic [3:0]     r_col;
  logic [AW-1:0]  r_addr;
  logic [3:0]     r_drain;
  logic           r_done;

  logic           w_active;
  logic           w_col_last;
  logic           w_row_last;
  logic           w_oc_last;
  logic           w_win;
  logic [TW-1:0]  w_tag_in;
  logic [TW-1:0]  w_tag_out;
  logic           w_out_valid;

  assign w_col_last = r_col == ((r_mode == MODE_CONV2) ? W2_LAST : W3_LAST);
  assign w_row_last = r_row == ROW_LAST;
  assign w_oc_last  = r_oc == (r_n_oc - OCW'(1));
  assign w_active   = (r_state == STREAM) || (r_state == DRAIN);

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_state <= IDLE;
      r_mode  <= 1'b0;
      r_layer <= '0;
      r_n_oc  <= '0;
      r_oc    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_addr  <= '0;
      r_drain <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.iGO) begin
            if (bus.iN_OC != '0) begin
              r_mode  <= bus.iMODE;
              r_layer <= bus.iLAYER;
              r_n_oc  <= bus.iN_OC;
              r_oc    <= '0;
              r_row   <= '0;
              r_col   <= '0;
              r_addr  <= '0;
              r_state <= STREAM;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        STREAM: begin
          r_addr <= r_addr + AW'(1);
          if (w_col_last) begin
            r_col <= '0;
            if (w_row_last) begin
              // End of one map pass: next channel restarts at address 0 with no gap.
              r_row  <= '0;
              r_addr <= '0;
              if (w_oc_last) begin
                r_drain <= '0;
                r_state <= DRAIN;
              end else begin
                r_oc <= r_oc + OCW'(1);
              end
            end else begin
              r_row <= r_row + 4'd1;
            end
          end else begin
            r_col <= r_col + 4'd1;
          end
        end
        DRAIN: begin
          r_drain <= r_drain + 4'd1;
          if (r_drain == DRN_LAST) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Only the current map's coordinates decide validity, so windows never span passes.
  assign w_win    = (r_state == STREAM) && (r_row >= 4'd2) && (r_col >= 4'd2);
  assign w_tag_in = {r_oc, r_row - 4'd2, r_col - 4'd2};

  bnn_tag_pipe #(
    .DEPTH (PIPE),
    .TW    (TW)
  ) u_tag_pipe (
    .i_clk   (iCLK),
    .i_clr_n (iRST),
    .i_valid (w_win),
    .i_tag   (w_tag_in),
    .o_valid (w_out_valid),
    .o_tag   (w_tag_out)
  );

  assign bus.oBUSY      = w_active;
  assign bus.oDONE      = r_done;
  assign bus.oRD_EN     = r_state == STREAM;
  assign bus.oRD_ADDR   = r_addr;
  assign bus.oW_ADDR    = r_oc;
  assign bus.oSTART     = w_active ? layer_onehot(r_layer) : 4'b0000;
  assign bus.oEN_conv2  = w_active && (r_mode == MODE_CONV2);
  assign bus.oEN_conv3  = w_active && (r_mode == MODE_CONV3);
  assign bus.oOUT_VALID = w_out_valid;
  assign {bus.oOUT_OC, bus.oOUT_ROW, bus.oOUT_COL} = w_tag_out;

endmodule
